// File: rtl/stdp_pkg.sv
// Shared fixed-point constants and saturating arithmetic helpers for the STDP synapse bank.
// All helpers work on 64-bit unsigned intermediates so callers never overflow before saturating.
package stdp_pkg;

  typedef logic [63:0] acc_t;

  localparam int DECIMAL_BITS_DEFAULT = 7;
  localparam int ONE = 1 << DECIMAL_BITS_DEFAULT;

  function automatic acc_t sat_add(input acc_t a, input acc_t b, input acc_t max_v);
    acc_t s;
    s = a + b;
    return (s > max_v) ? max_v : s;
  endfunction

  function automatic acc_t sat_sub(input acc_t a, input acc_t b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic acc_t clamp(input acc_t v, input acc_t lo, input acc_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Decay and spike increment are applied together, then saturated.
  function automatic acc_t trace_next(input acc_t t, input logic spike, input int shift,
                                      input acc_t one, input acc_t max_v);
    return sat_add(t - (t >> shift), spike ? one : '0, max_v);
  endfunction

endpackage

// File: rtl/stdp_synapse_array_if.sv
// Spike, learning-control and host weight-access bundle between a driver and the synapse bank.
interface stdp_synapse_array_if #(
  parameter int N_PRE = 4,
  parameter int WIDTH = 16
);
  localparam int IDX_W = $clog2(N_PRE) + 1;

  logic [N_PRE-1:0] pre_spike;
  logic             post_spike;
  logic             learn_en;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [IDX_W-1:0] rd_idx;
  logic [WIDTH-1:0] rd_weight;
  logic [WIDTH-1:0] i_syn;

  modport master (
    output pre_spike, post_spike, learn_en, wr_en, wr_idx, wr_data, rd_idx,
    input  rd_weight, i_syn
  );

  modport slave (
    input  pre_spike, post_spike, learn_en, wr_en, wr_idx, wr_data, rd_idx,
    output rd_weight, i_syn
  );
endinterface

// File: rtl/stdp_trace.sv
// One exponentially decaying spike trace: each cycle it loses 1/2^TRACE_SHIFT of itself and
// gains ONE on a spike, saturating at the register maximum.
module stdp_trace
  import stdp_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int TRACE_SHIFT  = 4,
  parameter int DECIMAL_BITS = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             spike,
  output logic [WIDTH-1:0] trace
);
  localparam acc_t MAX_V = (acc_t'(1) << WIDTH) - 1;
  localparam acc_t ONE_V = acc_t'(1) << DECIMAL_BITS;

  logic [WIDTH-1:0] trace_nxt;

  always_comb begin
    trace_nxt = WIDTH'(trace_next(acc_t'(trace), spike, TRACE_SHIFT, ONE_V, MAX_V));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trace <= '0;
    else          trace <= trace_nxt;
  end
endmodule

// File: rtl/stdp_synapse_array.sv
// STDP synapse bank: per-channel weights learned from pre/post traces, a saturated summed
// synaptic current and a host read/write port; all outputs registered with one cycle latency.
module stdp_synapse_array
  import stdp_pkg::*;
#(
  parameter int N_PRE         = 4,
  parameter int WIDTH         = 16,
  parameter int DECIMAL_BITS  = 7,
  parameter int TRACE_SHIFT   = 4,
  parameter int A_PLUS_SHIFT  = 5,
  parameter int A_MINUS_SHIFT = 6,
  parameter int W_INIT        = ONE,
  parameter int W_MAX         = 2 * ONE,
  parameter int I_SHIFT       = 2
) (
  input logic                 clk,
  input logic                 reset_n,
  stdp_synapse_array_if.slave bus
);
  localparam int   IDX_W   = $clog2(N_PRE) + 1;
  localparam acc_t MAX_V   = (acc_t'(1) << WIDTH) - 1;
  localparam acc_t W_MAX_A = acc_t'(W_MAX);

  logic [WIDTH-1:0] pre_trace [N_PRE];
  logic [WIDTH-1:0] post_trace;
  logic [WIDTH-1:0] w         [N_PRE];
  logic [WIDTH-1:0] w_nxt     [N_PRE];
  logic [WIDTH-1:0] i_syn_q, i_syn_nxt;
  logic [WIDTH-1:0] rd_q, rd_nxt;
  acc_t             d_plus, d_minus, w_upd, i_acc;

  for (genvar g = 0; g < N_PRE; g++) begin : g_pre
    stdp_trace #(.WIDTH(WIDTH), .TRACE_SHIFT(TRACE_SHIFT), .DECIMAL_BITS(DECIMAL_BITS)) u_pre (
      .clk(clk), .reset_n(reset_n), .spike(bus.pre_spike[g]), .trace(pre_trace[g])
    );
  end

  stdp_trace #(.WIDTH(WIDTH), .TRACE_SHIFT(TRACE_SHIFT), .DECIMAL_BITS(DECIMAL_BITS)) u_post (
    .clk(clk), .reset_n(reset_n), .spike(bus.post_spike), .trace(post_trace)
  );

  // Learning, current and readback all read the pre-update weights and traces.
  always_comb begin
    d_plus  = '0;
    d_minus = '0;
    w_upd   = '0;
    i_acc   = '0;
    rd_nxt  = '0;
    for (int k = 0; k < N_PRE; k++) begin
      d_plus  = '0;
      d_minus = '0;
      if (bus.learn_en && bus.post_spike && (pre_trace[k] != '0))
        d_plus = (acc_t'(pre_trace[k]) * (W_MAX_A - acc_t'(w[k]))) >> (DECIMAL_BITS + A_PLUS_SHIFT);
      if (bus.learn_en && bus.pre_spike[k] && (post_trace != '0))
        d_minus = (acc_t'(post_trace) * acc_t'(w[k])) >> (DECIMAL_BITS + A_MINUS_SHIFT);
      w_upd = clamp(sat_sub(acc_t'(w[k]) + d_plus, d_minus), '0, W_MAX_A);
      if (bus.wr_en && (bus.wr_idx == IDX_W'(k)))
        w_upd = clamp(acc_t'(bus.wr_data), '0, W_MAX_A);
      w_nxt[k] = WIDTH'(w_upd);
      if (bus.pre_spike[k])
        i_acc = i_acc + acc_t'(w[k] >> I_SHIFT);
      if (bus.rd_idx == IDX_W'(k))
        rd_nxt = w[k];
    end
    i_syn_nxt = WIDTH'(clamp(i_acc, '0, MAX_V));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < N_PRE; k++) w[k] <= WIDTH'(W_INIT);
      i_syn_q <= '0;
      rd_q    <= '0;
    end else begin
      for (int k = 0; k < N_PRE; k++) w[k] <= w_nxt[k];
      i_syn_q <= i_syn_nxt;
      rd_q    <= rd_nxt;
    end
  end

  assign bus.i_syn     = i_syn_q;
  assign bus.rd_weight = rd_q;
endmodule

// File: tb/tb_stdp_synapse_array.sv
// Directed and randomized checks of the STDP synapse bank against a plain-arithmetic reference.
module tb_stdp_synapse_array;
  localparam int    N     = 4;
  localparam int    W     = 16;
  localparam longint MAXV  = 65535;
  localparam longint ONE   = 128;
  localparam longint WMAX  = 256;
  localparam longint WINIT = 128;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  stdp_synapse_array_if #(.N_PRE(N), .WIDTH(W)) bus ();
  stdp_synapse_array #(.N_PRE(N), .WIDTH(W)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  longint m_pre [N];
  longint m_post;
  longint m_w   [N];
  longint m_isyn;
  longint m_rd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < N; k++) begin
      m_pre[k] = 0;
      m_w[k]   = WINIT;
    end
    m_post = 0;
    m_isyn = 0;
    m_rd   = 0;
  endfunction

  function automatic longint decay(input longint t, input logic s);
    longint r;
    r = t - t / 16 + (s ? ONE : 0);
    return (r > MAXV) ? MAXV : r;
  endfunction

  task automatic idle();
    bus.pre_spike  = '0;
    bus.post_spike = 1'b0;
    bus.learn_en   = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_idx     = '0;
    bus.wr_data    = '0;
    bus.rd_idx     = '0;
  endtask

  // Advance one clock: reference computes next state from current inputs, then outputs compared.
  task automatic step();
    longint nw [N];
    longint npre [N];
    longint npost, acc, v, nrd;
    int ri;
    acc = 0;
    for (int k = 0; k < N; k++) if (bus.pre_spike[k]) acc += m_w[k] / 4;
    ri  = int'(bus.rd_idx);
    nrd = (ri < N) ? m_w[ri] : 0;
    for (int k = 0; k < N; k++) begin
      v = m_w[k];
      if (bus.learn_en && bus.post_spike && m_pre[k] != 0) v += (m_pre[k] * (WMAX - m_w[k])) / 4096;
      if (bus.learn_en && bus.pre_spike[k] && m_post != 0) v -= (m_post * m_w[k]) / 8192;
      if (v < 0) v = 0;
      if (v > WMAX) v = WMAX;
      if (bus.wr_en && int'(bus.wr_idx) == k) v = (longint'(bus.wr_data) > WMAX) ? WMAX : longint'(bus.wr_data);
      nw[k]   = v;
      npre[k] = decay(m_pre[k], bus.pre_spike[k]);
    end
    npost = decay(m_post, bus.post_spike);
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      m_w[k]   = nw[k];
      m_pre[k] = npre[k];
    end
    m_post = npost;
    m_isyn = (acc > MAXV) ? MAXV : acc;
    m_rd   = nrd;
    check("i_syn", bus.i_syn, m_isyn);
    check("rd_weight", bus.rd_weight, m_rd);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    #2;
    model_reset();
    check("rst_i_syn", bus.i_syn, 0);
    check("rst_rd_weight", bus.rd_weight, 0);
    check("rst_post_trace", dut.post_trace, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic read_weight(input int k, input longint exp, input string tag);
    bus.rd_idx = 3'(k);
    step();
    check(tag, bus.rd_weight, exp);
  endtask

  initial begin
    logic [N-1:0] ps;
    int dec_exp [3];
    dec_exp = '{120, 113, 106};

    do_reset();

    // Trace decay from a single presynaptic spike
    bus.pre_spike = 4'b0001;
    step();
    check("trace_t0", dut.pre_trace[0], 128);
    bus.pre_spike = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("trace_decay", dut.pre_trace[0], dec_exp[i]);
    end

    // LTP: pre then post
    do_reset();
    bus.learn_en  = 1'b1;
    bus.pre_spike = 4'b0001;
    step();
    bus.pre_spike  = '0;
    bus.post_spike = 1'b1;
    step();
    bus.post_spike = 1'b0;
    read_weight(0, 132, "ltp_w0");

    // LTD: post then pre
    do_reset();
    bus.learn_en   = 1'b1;
    bus.post_spike = 1'b1;
    step();
    bus.post_spike = 1'b0;
    bus.pre_spike  = 4'b0010;
    step();
    bus.pre_spike = '0;
    read_weight(1, 126, "ltd_w1");
    read_weight(0, 128, "ltd_w0_unchanged");

    // Current summation, return to zero, write clamp
    do_reset();
    bus.pre_spike = 4'b0011;
    step();
    check("isyn_pair", bus.i_syn, 64);
    bus.pre_spike = '0;
    step();
    check("isyn_zero", bus.i_syn, 0);
    bus.wr_en   = 1'b1;
    bus.wr_idx  = 3'd2;
    bus.wr_data = 16'hFFFF;
    step();
    bus.wr_en     = 1'b0;
    bus.learn_en  = 1'b1;
    bus.pre_spike = 4'b1111;
    bus.rd_idx    = 3'd2;
    step();
    check("isyn_all", bus.i_syn, 160);
    check("wr_clamp", bus.rd_weight, 256);
    bus.pre_spike = '0;

    // Host write wins over a coincident LTP
    do_reset();
    bus.learn_en  = 1'b1;
    bus.pre_spike = 4'b0001;
    step();
    bus.pre_spike  = '0;
    bus.post_spike = 1'b1;
    bus.wr_en      = 1'b1;
    bus.wr_idx     = 3'd0;
    bus.wr_data    = 16'd50;
    step();
    idle();
    read_weight(0, 50, "wr_priority");

    // Frozen learning, out-of-range write and read
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.pre_spike = 4'(1 << i);
      step();
      bus.pre_spike  = '0;
      bus.post_spike = 1'b1;
      step();
      bus.post_spike = 1'b0;
      bus.pre_spike  = 4'(1 << i);
      step();
      bus.pre_spike = '0;
    end
    bus.wr_en   = 1'b1;
    bus.wr_idx  = 3'd4;
    bus.wr_data = 16'd7;
    step();
    bus.wr_en = 1'b0;
    read_weight(5, 0, "rd_out_of_range");
    for (int k = 0; k < N; k++) read_weight(k, 128, "frozen_w");

    // Randomized traffic with a mid-cycle asynchronous reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) ps[k] = ($urandom_range(3) == 0);
      bus.pre_spike  = ps;
      bus.post_spike = ($urandom_range(3) == 0);
      bus.learn_en   = ($urandom_range(7) != 0);
      bus.wr_en      = ($urandom_range(15) == 0);
      bus.wr_idx     = 3'($urandom_range(7));
      bus.wr_data    = ($urandom_range(1) == 0) ? 16'($urandom_range(300)) : 16'($urandom);
      bus.rd_idx     = 3'($urandom_range(7));
      if (i == 300) begin
        #3;
        reset_n = 1'b0;
        #1;
        model_reset();
        check("mid_rst_i_syn", bus.i_syn, 0);
        check("mid_rst_rd_weight", bus.rd_weight, 0);
        check("mid_rst_post_trace", dut.post_trace, 0);
        for (int k = 0; k < N; k++) check("mid_rst_pre_trace", dut.pre_trace[k], 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle();
        for (int k = 0; k < N; k++) read_weight(k, 128, "mid_rst_w");
      end else begin
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
